// File: rtl/shake_arb_pkg.sv
// Shared types and constants for the SHAKE core arbiter.
// Mode encodings match the core's start/config port.
package shake_arb_pkg;

  localparam int OUT_SIZE_W = 32;

  localparam logic [1:0] MODE_SHAKE128 = 2'b00;
  localparam logic [1:0] MODE_SHAKE256 = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_START   = 3'd2,
    ST_ABSORB  = 3'd3,
    ST_SQUEEZE = 3'd4,
    ST_RELEASE = 3'd5
  } arb_state_t;

endpackage

// File: rtl/shake_core_arbiter_rr_priority_pick.sv
// Round-robin priority picker: first set request bit at or above rr_ptr,
// wrapping around. Purely combinational.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;
  int               pos;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    pos        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found            = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/shake_core_arbiter.sv
// Shares one SHAKE core between NUM_REQ requesters, granting whole
// transactions (config, absorb stream, squeeze stream) round-robin.
module shake_core_arbiter
  import shake_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = 64,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [2*NUM_REQ-1:0]          req_mode,
  input  logic [OUT_SIZE_W*NUM_REQ-1:0] req_out_size,
  input  logic [W*NUM_REQ-1:0]          req_din,
  input  logic [NUM_REQ-1:0]            req_din_valid,
  input  logic [NUM_REQ-1:0]            req_din_last,
  output logic [NUM_REQ-1:0]            req_din_ready,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [W-1:0]                  req_dout,
  output logic [NUM_REQ-1:0]            req_dout_valid,
  input  logic [NUM_REQ-1:0]            req_dout_ready,
  output logic [NUM_REQ-1:0]            done,
  output logic                          core_start,
  output logic [1:0]                    core_mode,
  output logic [OUT_SIZE_W-1:0]         core_out_size,
  input  logic                          core_cfg_ready,
  output logic [W-1:0]                  core_din,
  output logic                          core_din_valid,
  output logic                          core_din_last,
  input  logic                          core_din_ready,
  input  logic [W-1:0]                  core_dout,
  input  logic                          core_dout_valid,
  input  logic                          core_dout_last,
  output logic                          core_dout_ready,
  output logic                          busy
);

  arb_state_t              state_reg, state_next;
  logic [NUM_REQ-1:0]      gnt_reg;
  logic [IDX_W-1:0]        gnt_idx_reg;
  logic [IDX_W-1:0]        rr_ptr_reg;
  logic [1:0]              mode_reg;
  logic [OUT_SIZE_W-1:0]   size_reg;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [W-1:0]            din_arr  [NUM_REQ];
  logic [1:0]              mode_arr [NUM_REQ];
  logic [OUT_SIZE_W-1:0]   size_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign din_arr[gi]  = req_din[gi*W +: W];
      assign mode_arr[gi] = req_mode[gi*2 +: 2];
      assign size_arr[gi] = req_out_size[gi*OUT_SIZE_W +: OUT_SIZE_W];
    end
  endgenerate

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_reg),
    .gnt_onehot (pick_gnt),
    .gnt_idx    (pick_idx),
    .any_req    (pick_any)
  );

  // Handshakes on the granted requester's streams
  logic absorb_fire, squeeze_fire;
  assign absorb_fire  = (state_reg == ST_ABSORB) && req_din_valid[gnt_idx_reg]
                        && core_din_ready && req_din_last[gnt_idx_reg];
  assign squeeze_fire = (state_reg == ST_SQUEEZE) && core_dout_valid
                        && req_dout_ready[gnt_idx_reg] && core_dout_last;

  always_comb begin
    state_next      = state_reg;
    core_start      = 1'b0;
    core_din        = '0;
    core_din_valid  = 1'b0;
    core_din_last   = 1'b0;
    core_dout_ready = 1'b0;
    req_din_ready   = '0;
    req_dout        = '0;
    req_dout_valid  = '0;
    done            = '0;
    case (state_reg)
      ST_IDLE:  if (pick_any) state_next = ST_GRANT;
      ST_GRANT: state_next = ST_START;
      ST_START: begin
        if (core_cfg_ready) begin
          core_start = 1'b1;
          state_next = ST_ABSORB;
        end
      end
      ST_ABSORB: begin
        core_din                   = din_arr[gnt_idx_reg];
        core_din_valid             = req_din_valid[gnt_idx_reg];
        core_din_last              = req_din_last[gnt_idx_reg];
        req_din_ready[gnt_idx_reg] = core_din_ready;
        // A zero-length output has nothing to squeeze
        if (absorb_fire) state_next = (size_reg == '0) ? ST_RELEASE : ST_SQUEEZE;
      end
      ST_SQUEEZE: begin
        req_dout                    = core_dout;
        req_dout_valid[gnt_idx_reg] = core_dout_valid;
        core_dout_ready             = req_dout_ready[gnt_idx_reg];
        if (squeeze_fire) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        done[gnt_idx_reg] = 1'b1;
        state_next        = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      gnt_reg     <= '0;
      gnt_idx_reg <= '0;
      rr_ptr_reg  <= '0;
      mode_reg    <= '0;
      size_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && pick_any) begin
        gnt_reg     <= pick_gnt;
        gnt_idx_reg <= pick_idx;
      end else if (state_next == ST_RELEASE) begin
        gnt_reg <= '0;
      end
      if (state_reg == ST_GRANT) begin
        mode_reg <= mode_arr[gnt_idx_reg];
        size_reg <= size_arr[gnt_idx_reg];
      end
      if (state_reg == ST_RELEASE) begin
        rr_ptr_reg <= (gnt_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_reg + 1'b1;
      end
    end
  end

  assign gnt           = gnt_reg;
  assign core_mode     = mode_reg;
  assign core_out_size = size_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_shake_core_arbiter.sv
// Directed bench for shake_core_arbiter: the bench plays both the requesters
// and the SHAKE core, checking every stream word against hand-built values.
module tb_shake_core_arbiter;
  import shake_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int W       = 64;
  localparam int IDX_W   = 2;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_REQ-1:0]            req;
  logic [2*NUM_REQ-1:0]          req_mode;
  logic [OUT_SIZE_W*NUM_REQ-1:0] req_out_size;
  logic [W*NUM_REQ-1:0]          req_din;
  logic [NUM_REQ-1:0]            req_din_valid;
  logic [NUM_REQ-1:0]            req_din_last;
  logic [NUM_REQ-1:0]            req_din_ready;
  logic [NUM_REQ-1:0]            gnt;
  logic [W-1:0]                  req_dout;
  logic [NUM_REQ-1:0]            req_dout_valid;
  logic [NUM_REQ-1:0]            req_dout_ready;
  logic [NUM_REQ-1:0]            done;
  logic                          core_start;
  logic [1:0]                    core_mode;
  logic [OUT_SIZE_W-1:0]         core_out_size;
  logic                          core_cfg_ready;
  logic [W-1:0]                  core_din;
  logic                          core_din_valid;
  logic                          core_din_last;
  logic                          core_din_ready;
  logic [W-1:0]                  core_dout;
  logic                          core_dout_valid;
  logic                          core_dout_last;
  logic                          core_dout_ready;
  logic                          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shake_core_arbiter #(.NUM_REQ(NUM_REQ), .W(W), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_mode       (req_mode),
    .req_out_size   (req_out_size),
    .req_din        (req_din),
    .req_din_valid  (req_din_valid),
    .req_din_last   (req_din_last),
    .req_din_ready  (req_din_ready),
    .gnt            (gnt),
    .req_dout       (req_dout),
    .req_dout_valid (req_dout_valid),
    .req_dout_ready (req_dout_ready),
    .done           (done),
    .core_start     (core_start),
    .core_mode      (core_mode),
    .core_out_size  (core_out_size),
    .core_cfg_ready (core_cfg_ready),
    .core_din       (core_din),
    .core_din_valid (core_din_valid),
    .core_din_last  (core_din_last),
    .core_din_ready (core_din_ready),
    .core_dout      (core_dout),
    .core_dout_valid(core_dout_valid),
    .core_dout_last (core_dout_last),
    .core_dout_ready(core_dout_ready),
    .busy           (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] onehot(input int idx);
    return 64'(1) << idx;
  endfunction

  function automatic logic [63:0] absorb_word(input int idx, input int k);
    return 64'hA5A5_0000_0000_0000 | (64'(idx) << 16) | 64'(k);
  endfunction

  function automatic logic [63:0] squeeze_word(input int idx, input int k);
    return 64'h5A5A_0000_0000_0000 | (64'(idx) << 16) | 64'(k);
  endfunction

  // Feed n absorb words from requester idx; bp toggles core_din_ready.
  task automatic absorb(input int idx, input int n, input bit bp);
    int k = 0;
    int c = 0;
    logic [63:0] w;
    while (k < n && c < 60) begin
      w = absorb_word(idx, k);
      req_din[idx*W +: W] = w;
      req_din_valid[idx]  = 1'b1;
      req_din_last[idx]   = (k == n - 1);
      core_din_ready      = bp ? c[0] : 1'b1;
      #1;
      check_eq("core_din", core_din, w);
      check_eq("core_din_valid", {63'd0, core_din_valid}, 64'd1);
      check_eq("core_din_last", {63'd0, core_din_last}, {63'd0, (k == n - 1)});
      check_eq("req_din_ready", {60'd0, req_din_ready}, core_din_ready ? onehot(idx) : 64'd0);
      if (core_din_ready) k++;
      step();
      c++;
    end
    check_eq("absorb_count", 64'(k), 64'(n));
    req_din_valid[idx] = 1'b0;
    req_din_last[idx]  = 1'b0;
    core_din_ready     = 1'b1;
  endtask

  // Deliver n squeeze words to requester idx, consumer stalled for the first stall cycles.
  task automatic squeeze(input int idx, input int n, input int stall);
    int k = 0;
    int c = 0;
    logic [63:0] w;
    while (k < n && c < 60) begin
      w = squeeze_word(idx, k);
      core_dout           = w;
      core_dout_valid     = 1'b1;
      core_dout_last      = (k == n - 1);
      req_dout_ready[idx] = (c >= stall);
      #1;
      check_eq("req_dout", req_dout, w);
      check_eq("req_dout_valid", {60'd0, req_dout_valid}, onehot(idx));
      check_eq("core_dout_ready", {63'd0, core_dout_ready}, {63'd0, req_dout_ready[idx]});
      if (req_dout_ready[idx]) k++;
      step();
      c++;
    end
    check_eq("squeeze_count", 64'(k), 64'(n));
    core_dout_valid = 1'b0;
    core_dout_last  = 1'b0;
    req_dout_ready  = '1;
  endtask

  // One whole transaction, entered and left with the arbiter in IDLE.
  task automatic txn(input int idx, input logic [1:0] mode, input logic [31:0] size,
                     input int na, input int ns, input bit bp, input int stall,
                     input int cfg_delay, input bit hold);
    req_mode[idx*2 +: 2]      = mode;
    req_out_size[idx*32 +: 32] = size;
    req[idx] = 1'b1;
    #1;
    check_eq("idle_gnt", {60'd0, gnt}, 64'd0);
    check_eq("idle_busy", {63'd0, busy}, 64'd0);
    step();
    check_eq("gnt", {60'd0, gnt}, onehot(idx));
    check_eq("grant_busy", {63'd0, busy}, 64'd1);
    if (!hold) req = '0;
    core_cfg_ready = (cfg_delay == 0);
    step();
    for (int c = 0; c < cfg_delay; c++) begin
      #1;
      check_eq("start_held", {63'd0, core_start}, 64'd0);
      step();
    end
    core_cfg_ready = 1'b1;
    #1;
    check_eq("core_start", {63'd0, core_start}, 64'd1);
    check_eq("core_mode", {62'd0, core_mode}, {62'd0, mode});
    check_eq("core_out_size", {32'd0, core_out_size}, {32'd0, size});
    step();
    check_eq("start_once", {63'd0, core_start}, 64'd0);
    absorb(idx, na, bp);
    if (size != 0) begin
      squeeze(idx, ns, stall);
    end else begin
      core_dout_valid = 1'b1;
      #1;
      check_eq("zero_no_dout", {60'd0, req_dout_valid}, 64'd0);
      check_eq("zero_no_ready", {63'd0, core_dout_ready}, 64'd0);
      core_dout_valid = 1'b0;
    end
    #1;
    check_eq("done", {60'd0, done}, onehot(idx));
    check_eq("release_gnt", {60'd0, gnt}, 64'd0);
    step();
    check_eq("done_pulse", {60'd0, done}, 64'd0);
    check_eq("gap_gnt", {60'd0, gnt}, 64'd0);
    $display("txn: req %0d mode %0d size %0d absorb %0d squeeze %0d", idx, mode, size, na, ns);
  endtask

  initial begin
    rst             = 1'b0;
    req             = '0;
    req_mode        = '0;
    req_out_size    = '0;
    req_din         = '0;
    req_din_valid   = '0;
    req_din_last    = '0;
    req_dout_ready  = '1;
    core_cfg_ready  = 1'b1;
    core_din_ready  = 1'b1;
    core_dout       = 64'hDEAD_BEEF_0000_0001;
    core_dout_valid = 1'b1;
    core_dout_last  = 1'b0;
    req_din_valid   = '1;
    repeat (3) step();
    check_eq("rst_gnt", {60'd0, gnt}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_start", {63'd0, core_start}, 64'd0);
    check_eq("rst_req_dout", req_dout, 64'd0);
    check_eq("rst_dout_valid", {60'd0, req_dout_valid}, 64'd0);
    check_eq("rst_din_valid", {63'd0, core_din_valid}, 64'd0);
    check_eq("rst_cfg", {30'd0, core_mode, core_out_size}, 64'd0);
    core_dout_valid = 1'b0;
    req_din_valid   = '0;
    rst = 1'b1;
    step();

    // Round-robin with everyone requesting continuously
    req = 4'b1111;
    txn(0, MODE_SHAKE128, 32'd64, 1, 1, 1'b0, 0, 0, 1'b1);
    txn(1, MODE_SHAKE256, 32'd64, 1, 1, 1'b0, 0, 0, 1'b1);
    txn(2, MODE_SHAKE128, 32'd64, 1, 1, 1'b0, 0, 0, 1'b1);
    txn(3, MODE_SHAKE256, 32'd64, 1, 1, 1'b0, 0, 0, 1'b1);
    txn(0, MODE_SHAKE128, 32'd64, 1, 1, 1'b0, 0, 0, 1'b0);

    // Single requester 0: 3 absorb words, 256-bit output
    txn(0, MODE_SHAKE128, 32'd256, 3, 4, 1'b0, 0, 0, 1'b0);
    // Backpressure on requester 2
    txn(2, MODE_SHAKE256, 32'd320, 4, 5, 1'b1, 5, 0, 1'b0);
    // Zero-length output on requester 1
    txn(1, MODE_SHAKE256, 32'd0, 2, 0, 1'b0, 0, 0, 1'b0);
    // Core busy for 10 cycles after grant
    txn(2, MODE_SHAKE256, 32'd64, 1, 1, 1'b0, 0, 10, 1'b0);

    // Reset in mid-squeeze on requester 3 (rr_ptr is 3 at this point)
    req_mode[6 +: 2]   = MODE_SHAKE128;
    req_out_size[96 +: 32] = 32'd128;
    req = 4'b1000;
    step();
    check_eq("mid_gnt", {60'd0, gnt}, 64'd8);
    req = '0;
    step();
    step();
    absorb(3, 1, 1'b0);
    core_dout       = squeeze_word(3, 0);
    core_dout_valid = 1'b1;
    #1;
    check_eq("mid_dout_valid", {60'd0, req_dout_valid}, 64'd8);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_gnt", {60'd0, gnt}, 64'd0);
    check_eq("arst_done", {60'd0, done}, 64'd0);
    check_eq("arst_dout_valid", {60'd0, req_dout_valid}, 64'd0);
    check_eq("arst_start", {63'd0, core_start}, 64'd0);
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_req_dout", req_dout, 64'd0);
    core_dout_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    req = 4'b1011;
    txn(0, MODE_SHAKE128, 32'd64, 1, 1, 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/shake_core_arbiter.md
Name: shake_core_arbiter

Overview:
- Shares one SHAKE core between NUM_REQ requesters, e.g. matrix expansion, rejection sampler and hash-of-message units.
- The SHAKE core is the full pipeline: absorb buffer, permute stage and squeeze buffer.
- Grants whole transactions round-robin: configuration, absorb stream, then squeeze stream.
- Sits between the Dilithium compute units and the shake top; owns the core's start/config port and the muxing of its input and output streams.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- W, 64: data word width of the absorb and squeeze streams.
- IDX_W, $clog2(NUM_REQ): requester index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transaction request.
- req_mode  in  2*NUM_REQ  per-requester operation mode (package encoding).
- req_out_size  in  32*NUM_REQ  per-requester output size in bits.
- req_din  in  W*NUM_REQ  per-requester absorb data.
- req_din_valid  in  NUM_REQ  absorb word valid.
- req_din_last  in  NUM_REQ  last absorb word.
- req_din_ready  out  NUM_REQ  absorb word accepted.
- gnt  out  NUM_REQ  one-hot grant, registered.
- req_dout  out  W  squeeze data, broadcast to all requesters.
- req_dout_valid  out  NUM_REQ  squeeze word valid, granted requester only.
- req_dout_ready  in  NUM_REQ  squeeze consumer ready.
- done  out  NUM_REQ  one-cycle pulse per requester at transaction end.
- core_start  out  1  start pulse to the core.
- core_mode  out  2  mode to the core.
- core_out_size  out  32  output size to the core.
- core_cfg_ready  in  1  core idle, can take a start.
- core_din  out  W  absorb data to the core.
- core_din_valid  out  1  absorb valid to the core.
- core_din_last  out  1  absorb last to the core.
- core_din_ready  in  1  core accepts an absorb word.
- core_dout  in  W  squeeze data from the core.
- core_dout_valid  in  1  squeeze valid from the core.
- core_dout_last  in  1  last squeeze word.
- core_dout_ready  out  1  arbiter accepts a squeeze word.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE, rr_ptr=0. gnt, done, core_start, busy, all valid/ready outputs are 0; core_mode, core_out_size, req_dout are 0.
- FSM states: IDLE, GRANT, START, ABSORB, SQUEEZE, RELEASE.
- IDLE: if any req, select the first set bit scanning from rr_ptr upward with wrap-around. Register gnt one-hot and gnt_idx; go to GRANT. Latency req→gnt is 1 cycle.
- GRANT: latch mode and out_size of gnt_idx into registers that drive core_mode/core_out_size. These hold until RELEASE. Go to START.
- START: assert core_start when core_cfg_ready=1 (a one-cycle pulse), then go to ABSORB. If core_cfg_ready=0, wait in START with core_start=0.
- ABSORB: combinational pass-through. core_din/valid/last come from gnt_idx; req_din_ready[gnt_idx]=core_din_ready; other ready bits are 0. A handshake with last=1 moves the FSM to SQUEEZE.
- SQUEEZE: req_dout=core_dout. req_dout_valid[gnt_idx]=core_dout_valid. core_dout_ready=req_dout_ready[gnt_idx]. A handshake with core_dout_last=1 moves the FSM to RELEASE.
- RELEASE: for one cycle, gnt=0 and done[gnt_idx]=1. Set rr_ptr=(gnt_idx+1) mod NUM_REQ, then go to IDLE. Minimum gap between transactions is 2 cycles (RELEASE, IDLE).
- Lockout: a requester deasserting req after grant is ignored; the transaction runs to core_dout_last. Requests not yet granted may be withdrawn freely.
- Zero output: if the latched out_size==0, SQUEEZE is skipped and ABSORB last goes straight to RELEASE. done still pulses.
- Simultaneous requests: round-robin from rr_ptr. No requester waits more than NUM_REQ-1 transactions.
- Non-granted requesters always see din_ready=0 and dout_valid=0.
- Reset mid-transaction drops everything. The core must be reset by the same rst.

Decomposition:
- Package shake_arb_pkg holds: typedef arb_state_t (6 states); mode encodings MODE_SHAKE128=2'b00 and MODE_SHAKE256=2'b01; OUT_SIZE_W=32.
- One sub-module, rr_priority_pick: combinational, takes req vector and rr_ptr, returns one-hot grant, index and any_req.
- The FSM and stream muxes stay in the top.

Test Plan:
- Single requester 0, mode=SHAKE128, out_size=256, 3 absorb words → gnt[0] 1 cycle after req, core_start one pulse with mode=00 and size=256. 3 words reach the core; 4 dout words reach requester 0; done[0] pulses once.
- req=4'b1111 held continuously, 1-word absorb and 1-word squeeze each → grant order 0,1,2,3,0, with a 2-cycle gap between grants.
- Backpressure: core_din_ready toggles every other cycle and req_dout_ready[2]=0 for 5 cycles → no word lost or duplicated; core_dout_ready tracks req_dout_ready[2]; other requesters' valid/ready stay 0.
- out_size=0 on requester 1 → no dout_valid; done[1] pulses 1 cycle after the absorb last handshake.
- core_cfg_ready=0 for 10 cycles after grant → FSM holds in START with core_start=0. Exactly one core_start fires when ready rises.
- rst low in mid-SQUEEZE → gnt, done, all valids and core_start are 0 immediately; after release, rr_ptr=0 and requester 0 wins over 3 simultaneous requests.
